// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// PC step, NOP encoding and PC alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] INST_NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Force a target address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_stats.sv
// Fetch statistics counters: accepted fetches and output-slot bubbles.
// Only instantiated when FETCH_STATS_EN is defined. Both counters wrap.
module fetch_stats (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        accept_i,
  input  logic        bubble_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
);

  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Count accepted acks and empty-slot cycles outside IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (accept_i) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (bubble_i) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues one request at a time to a
// variable-latency req/ack instruction memory and presents {pc, inst} in a
// one-entry output slot for IF/ID. Redirects from ID override stalls and
// in-flight data; a request already issued is drained before the new target
// is fetched. Optional FETCH_STATS_EN adds fetch/bubble counter outputs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  slot_pc_q, slot_pc_d;
  logic [31:0]  slot_inst_q, slot_inst_d;
  logic         valid_q, valid_d;
  logic [31:0]  req_addr_q;

  // State, PC and output slot registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      slot_pc_q   <= 32'd0;
      slot_inst_q <= INST_NOP;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      slot_pc_q   <= slot_pc_d;
      slot_inst_q <= slot_inst_d;
      valid_q     <= valid_d;
    end
  end

  // Freeze the address of the outstanding request while it is drained, so a
  // redirect can update pc_q without disturbing the memory handshake.
  always_ff @(posedge clk_i) begin
    if (state_q != ST_DRAIN) req_addr_q <= pc_q;
  end

  // Next-state and slot update; redirect overrides stall and ack data.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    slot_pc_d   = slot_pc_q;
    slot_inst_d = slot_inst_q;
    valid_d     = valid_q;
    if (redirect_i) begin
      pc_d        = align_pc(redirect_pc_i);
      slot_pc_d   = 32'd0;
      slot_inst_d = INST_NOP;
      valid_d     = 1'b0;
      if ((state_q == ST_REQ || state_q == ST_DRAIN) && !imem_ack_i)
        state_d = ST_DRAIN;
      else
        state_d = ST_REQ;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_ack_i) begin
            slot_pc_d   = pc_q;
            slot_inst_d = imem_rdata_i;
            valid_d     = 1'b1;
            pc_d        = pc_q + PC_STEP;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (valid_q && !stall_i) begin
            valid_d = 1'b0;
            state_d = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_ack_i) state_d = ST_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign imem_req_o  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign imem_addr_o = (state_q == ST_DRAIN) ? req_addr_q : pc_q;
  assign pc_o        = slot_pc_q;
  assign inst_o      = slot_inst_q;
  assign valid_o     = valid_q;

`ifdef FETCH_STATS_EN
  logic accept;
  logic bubble;

  assign accept = (state_q == ST_REQ) && imem_ack_i && !redirect_i;
  assign bubble = !valid_q && (state_q != ST_IDLE);

  fetch_stats u_stats (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .accept_i     (accept),
    .bubble_i     (bubble),
    .fetch_cnt_o  (fetch_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );
`endif

endmodule
